// File: rtl/predecode_queue.sv
// Small FIFO of fetched MIPS words. Each word is decoded at push time, so the consumer
// sees register fields, the extended immediate, the branch/jump target and the class flags straight from storage.
module predecode_queue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned BRANCH_BASE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [31:0]             in_data,
    input  logic [31:0]             in_pc,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [5:0]              out_opcode,
    output logic [4:0]              out_rs,
    output logic [4:0]              out_rt,
    output logic [4:0]              out_rd,
    output logic [4:0]              out_shamt,
    output logic [5:0]              out_funct,
    output logic [31:0]             out_imm,
    output logic [31:0]             out_pc,
    output logic [31:0]             out_target,
    output logic                    out_is_branch,
    output logic                    out_is_jump,
    output logic                    out_illegal,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] target;
        logic        is_branch;
        logic        is_jump;
        logic        illegal;
    } entry_t;

    entry_t         mem [DEPTH];
    entry_t         dec;
    entry_t         head;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           push;
    logic           pop;
    logic [31:0]    pc_plus4;
    logic [31:0]    imm_sext;
    logic [31:0]    br_base;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != CW'(0));
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign pc_plus4  = in_pc + 32'd4;
    assign imm_sext  = {{16{in_data[15]}}, in_data[15:0]};
    assign br_base   = (BRANCH_BASE != 0) ? pc_plus4 : in_pc;

    // Decode the incoming word; fields are always captured, imm/target only for their classes.
    always_comb begin
        dec           = '0;
        dec.opcode    = in_data[31:26];
        dec.rs        = in_data[25:21];
        dec.rt        = in_data[20:16];
        dec.rd        = in_data[15:11];
        dec.shamt     = in_data[10:6];
        dec.funct     = in_data[5:0];
        dec.pc        = in_pc;
        case (in_data[31:26])
            6'b000000: ;
            6'b000010, 6'b000011: begin
                dec.is_jump = 1'b1;
                dec.target  = {pc_plus4[31:28], in_data[25:0], 2'b00};
            end
            6'b000100, 6'b000101: begin
                dec.is_branch = 1'b1;
                dec.imm       = imm_sext;
                dec.target    = br_base + {imm_sext[29:0], 2'b00};
            end
            6'b001001, 6'b001010, 6'b001011, 6'b100011, 6'b101011:
                dec.imm = imm_sext;
            6'b001100, 6'b001101, 6'b001110:
                dec.imm = {16'h0000, in_data[15:0]};
            6'b001111:
                dec.imm = {in_data[15:0], 16'h0000};
            default:
                dec.illegal = 1'b1;
        endcase
    end

    // Pointers and occupancy; reset outranks flush, flush outranks push/pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (!push && pop)
                count <= count - CW'(1);
        end
    end

    // Entry storage is written once at push and never touched again.
    always_ff @(posedge clk) begin
        if (push && !reset && !flush)
            mem[wr_ptr] <= dec;
    end

    assign head          = out_valid ? mem[rd_ptr] : '0;
    assign out_opcode    = head.opcode;
    assign out_rs        = head.rs;
    assign out_rt        = head.rt;
    assign out_rd        = head.rd;
    assign out_shamt     = head.shamt;
    assign out_funct     = head.funct;
    assign out_imm       = head.imm;
    assign out_pc        = head.pc;
    assign out_target    = head.target;
    assign out_is_branch = head.is_branch;
    assign out_is_jump   = head.is_jump;
    assign out_illegal   = head.illegal;

endmodule

// File: tb/tb_predecode_queue.sv
// Scoreboard bench for predecode_queue: two instances (branch base PC+4 and PC) share stimulus;
// a negedge monitor checks every presented head entry against hand-computed expectations.
module tb_predecode_queue;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] t1;
        logic [31:0] t0;
        logic        br;
        logic        jmp;
        logic        ill;
        logic        vb;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_data, in_pc;

    logic        in_ready_a, out_valid_a, br_a, jmp_a, ill_a;
    logic [5:0]  opc_a, fun_a;
    logic [4:0]  rs_a, rt_a, rd_a, sh_a;
    logic [31:0] imm_a, pc_a, tgt_a;
    logic [2:0]  count_a;

    logic        in_ready_b, out_valid_b, br_b, jmp_b, ill_b;
    logic [5:0]  opc_b, fun_b;
    logic [4:0]  rs_b, rt_b, rd_b, sh_b;
    logic [31:0] imm_b, pc_b, tgt_b;
    logic [2:0]  count_b;

    int n_vec = 0;
    int n_err = 0;
    int cur_idx = 0;
    exp_t exp_q[$];

    // Hand-computed table: instruction, pc, imm, target(base PC+4), target(base PC), {br,jmp,ill}
    logic [31:0] ins_t [16] = '{32'h24020005, 32'h1000FFFF, 32'h08000010, 32'h3042FFFF,
                                32'h3C011234, 32'hFC000000, 32'h8FA40010, 32'hAFA4FFF0,
                                32'h00851021, 32'h1485FFFE, 32'h0FFFFFFF, 32'h380AFFFF,
                                32'h40000000, 32'h2801FFFF, 32'h2C018000, 32'h34018001};
    logic [31:0] pc_t  [16] = '{32'hBFC00000, 32'hBFC00010, 32'hBFC00000, 32'hBFC00004,
                                32'hBFC00008, 32'hBFC0000C, 32'hBFC00014, 32'hBFC00018,
                                32'hBFC0001C, 32'h00000000, 32'hEFFFFFFC, 32'hBFC00020,
                                32'hBFC00024, 32'hBFC00028, 32'hBFC0002C, 32'hBFC00030};
    logic [31:0] imm_t [16] = '{32'h00000005, 32'hFFFFFFFF, 32'h00000000, 32'h0000FFFF,
                                32'h12340000, 32'h00000000, 32'h00000010, 32'hFFFFFFF0,
                                32'h00000000, 32'hFFFFFFFE, 32'h00000000, 32'h0000FFFF,
                                32'h00000000, 32'hFFFFFFFF, 32'hFFFF8000, 32'h00008001};
    logic [31:0] t1_t  [16] = '{32'h0, 32'hBFC00010, 32'hB0000040, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                32'h0, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] t0_t  [16] = '{32'h0, 32'hBFC0000C, 32'hB0000040, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                32'h0, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [2:0]  cls_t [16] = '{3'b000, 3'b100, 3'b010, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000,
                                3'b000, 3'b100, 3'b010, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000};

    predecode_queue #(.DEPTH(4), .BRANCH_BASE(1)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_pc(in_pc), .in_ready(in_ready_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_opcode(opc_a), .out_rs(rs_a), .out_rt(rt_a), .out_rd(rd_a), .out_shamt(sh_a),
        .out_funct(fun_a), .out_imm(imm_a), .out_pc(pc_a), .out_target(tgt_a),
        .out_is_branch(br_a), .out_is_jump(jmp_a), .out_illegal(ill_a), .count(count_a));

    predecode_queue #(.DEPTH(4), .BRANCH_BASE(0)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_pc(in_pc), .in_ready(in_ready_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_opcode(opc_b), .out_rs(rs_b), .out_rt(rt_b), .out_rd(rd_b), .out_shamt(sh_b),
        .out_funct(fun_b), .out_imm(imm_b), .out_pc(pc_b), .out_target(tgt_b),
        .out_is_branch(br_b), .out_is_jump(jmp_b), .out_illegal(ill_b), .count(count_b));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    function automatic exp_t mk_exp(input int i);
        exp_t e;
        logic [31:0] w;
        w        = ins_t[i];
        e.opcode = w[31:26];
        e.rs     = w[25:21];
        e.rt     = w[20:16];
        e.rd     = w[15:11];
        e.shamt  = w[10:6];
        e.funct  = w[5:0];
        e.imm    = imm_t[i];
        e.pc     = pc_t[i];
        e.t1     = t1_t[i];
        e.t0     = t0_t[i];
        {e.br, e.jmp, e.ill} = cls_t[i];
        e.vb     = 1'b1;
        return e;
    endfunction

    // Record the expected entry when the push will be taken at the coming edge, then advance.
    task automatic cyc();
        if (in_valid && in_ready_a && !flush && !reset)
            exp_q.push_back(mk_exp(cur_idx));
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int i);
        cur_idx  = i;
        in_data  = ins_t[i];
        in_pc    = pc_t[i];
        in_valid = 1'b1;
    endtask

    task automatic push_one(input int i);
        set_in(i);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        out_ready = 1'b1;
        for (k = 0; k < 40; k++) begin
            if (count_a == 3'd0 && exp_q.size() == 0) break;
            cyc();
        end
        check("drain_done", 256'(k < 40), 256'(1));
    endtask

    // Monitor: compare the presented head every cycle, pop on handshake.
    always @(negedge clk) begin
        exp_t got;
        if (reset || flush) begin
            exp_q.delete();
        end else if (out_valid_a) begin
            got = '{opcode: opc_a, rs: rs_a, rt: rt_a, rd: rd_a, shamt: sh_a, funct: fun_a,
                    imm: imm_a, pc: pc_a, t1: tgt_a, t0: tgt_b, br: br_a, jmp: jmp_a,
                    ill: ill_a, vb: out_valid_b};
            if (exp_q.size() == 0) begin
                check("unexpected_head", 256'(got), 256'(0));
            end else begin
                check("head_entry", 256'(got), 256'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end else begin
            check("idle_zero", {opc_a, rs_a, rt_a, rd_a, sh_a, fun_a, imm_a, pc_a, tgt_a,
                                br_a, jmp_a, ill_a, out_valid_b, tgt_b}, 256'(0));
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_pc = '0;
        cyc();
        cyc();
        check("reset_count", 256'(count_a), 256'(0));
        check("reset_in_ready", 256'(in_ready_a), 256'(1));
        check("reset_out_valid", 256'(out_valid_a), 256'(0));
        reset = 1'b0;
        cyc();

        // First push into empty queue is visible right after the edge.
        push_one(0);
        check("latency_valid", 256'(out_valid_a), 256'(1));
        check("latency_count", 256'(count_a), 256'(1));
        out_ready = 1'b1;
        cyc();
        check("pop_count", 256'(count_a), 256'(0));

        // Stream all vectors back to back with the consumer always ready.
        for (int i = 1; i < 16; i++) push_one(i);
        drain();

        // Fill to DEPTH, fifth word held, one pop frees a slot, order kept across wrap.
        out_ready = 1'b0;
        for (int i = 2; i < 6; i++) push_one(i);
        check("full_count", 256'(count_a), 256'(4));
        check("full_in_ready", 256'(in_ready_a), 256'(0));
        set_in(6);
        cyc();
        check("full_held", 256'(count_a), 256'(4));
        out_ready = 1'b1;
        cyc();
        check("full_pop_count", 256'(count_a), 256'(3));
        check("full_pop_ready", 256'(in_ready_a), 256'(1));
        out_ready = 1'b0;
        cyc();
        in_valid = 1'b0;
        check("refill_count", 256'(count_a), 256'(4));
        drain();

        // Flush with simultaneous push and pop.
        out_ready = 1'b0;
        push_one(7);
        push_one(8);
        check("pre_flush_count", 256'(count_a), 256'(2));
        flush = 1'b1;
        out_ready = 1'b1;
        set_in(9);
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_count", 256'(count_a), 256'(0));
        check("flush_out_valid", 256'(out_valid_a), 256'(0));
        push_one(10);
        drain();

        // Reset in the middle of a stream.
        out_ready = 1'b0;
        push_one(11);
        push_one(13);
        push_one(14);
        check("pre_reset_count", 256'(count_a), 256'(3));
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("mid_reset_count", 256'(count_a), 256'(0));
        check("mid_reset_in_ready", 256'(in_ready_a), 256'(1));
        check("mid_reset_out_valid", 256'(out_valid_a), 256'(0));
        push_one(15);
        check("post_reset_latency", 256'(out_valid_a), 256'(1));
        drain();

        check("scoreboard_empty", 256'(exp_q.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/predecode_queue.md
PREDECODE_QUEUE -- requirements
Module: predecode_queue

Interface
REQ-001 Parameter DEPTH, default 4: entry count; power of two, >=2.
REQ-002 Parameter BRANCH_BASE, default 1: branch-target base; 0 = entry PC, 1 = PC+4 (MIPS delay-slot semantics).
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  discard all entries (redirect).
REQ-007 in_valid  in  1  fetch word present.
REQ-008 in_data  in  32  raw instruction word.
REQ-009 in_pc  in  32  PC of in_data.
REQ-010 in_ready  out  1  queue can accept.
REQ-011 out_valid  out  1  head entry valid.
REQ-012 out_ready  in  1  consumer takes head.
REQ-013 out_opcode  out  6 / out_rs, out_rt, out_rd, out_shamt  out  5 each / out_funct  out  6: head fields.
REQ-014 out_imm  out  32  extended immediate.
REQ-015 out_pc  out  32  head PC.
REQ-016 out_target  out  32  precomputed branch/jump target.
REQ-017 out_is_branch, out_is_jump, out_illegal  out  1 each  class flags.
REQ-018 count  out  $clog2(DEPTH)+1  occupancy.

Function
REQ-019 Push when in_valid && in_ready; pop when out_valid && out_ready; both allowed same cycle.
REQ-020 in_ready SHALL equal (count != DEPTH); no combinational dependence on out_ready.
REQ-021 out_valid SHALL equal (count != 0); out_* driven from head entry registers only.
REQ-022 Latency: word pushed into empty queue at edge N is visible on out_* in cycle N+1.
REQ-023 Decode performed at push, stored with entry; field slices: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0], always stored regardless of class.
REQ-024 out_imm: ADDIU/SLTI/SLTIU/LW/SW/BEQ/BNE sign-extend [15:0]; ANDI/ORI/XORI zero-extend; LUI {[15:0],16'h0}; others 0.
REQ-025 Branch (BEQ 000100, BNE 000101): is_branch=1, target = base + {sext([15:0]),2'b00}, base per BRANCH_BASE, mod 2^32.
REQ-026 Jump (J 000010, JAL 000011): is_jump=1, target = {(pc+4)[31:28],[25:0],2'b00}.
REQ-027 Non-branch/jump: target = 0.
REQ-028 Legal opcodes: 000000, J, JAL, BEQ, BNE, 001001-001111, 100011, 101011; any other sets illegal=1 (entry still queued, imm/target 0).
REQ-029 Pointers wrap modulo DEPTH; count increments on push-only, decrements on pop-only, unchanged on push+pop.
REQ-030 Full: push+pop same cycle not allowed (in_ready=0); pop only.
REQ-031 Flush: next edge count=0, pointers=0; simultaneous push and pop ignored; flush has priority over push/pop.
REQ-032 Entries never modified after push; no output change while out_valid && !out_ready.

Reset
REQ-033 reset: next edge count=0, pointers=0, out_valid=0, in_ready=1; priority over flush, push, pop.
REQ-034 Entry storage need not be reset; out_* data outputs SHALL read 0 whenever out_valid=0.
REQ-035 reset asserted mid-stream discards all entries; first push after deassert behaves per REQ-022.

Verification
REQ-036 Push 0x24020005 @pc 0xBFC00000 -> next cycle out_valid=1, rs=0, rt=2, imm=0x00000005, illegal=0.
REQ-037 BRANCH_BASE=1, push 0x1000FFFF @pc 0xBFC00010 -> is_branch=1, target=0xBFC00010; BRANCH_BASE=0 -> 0xBFC0000C.
REQ-038 Push 0x08000010 @0xBFC00000 -> is_jump=1, target=0xB0000040; push 0x3042FFFF -> imm=0x0000FFFF; push 0x3C011234 -> imm=0x12340000.
REQ-039 DEPTH=4, out_ready=0, 5 pushes -> count=4, in_ready=0, 5th held; one pop -> count=3 next cycle, FIFO order preserved across wrap.
REQ-040 count=2, flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, no entry retained.
REQ-041 Push 0xFC000000 -> illegal=1, imm=0, target=0; reset mid-stream with count=3 -> count=0, in_ready=1.
